// File: rtl/alu_step_controller.sv
// Purpose : step-by-step operand/opcode entry from two pushbuttons, drives an external ALU and captures its output.
// Latency : a press acts on the 3rd clk_btn edge after the key is first sampled low (+DEBOUNCE_CYCLES with the filter);
//           the result is captured ALU_LATENCY cycles after alu_start.
// Backpressure: none; presses that arrive while an execution is in flight are dropped, not queued.
//
// Ports:
//   clk_btn, rst_btn          : clock (CLOCK_50) and synchronous active-high reset
//   key_advance, key_back     : raw active-low pushbuttons (asynchronous, idle 1)
//   sw_data                   : board switches, loaded into op_a / op_b / opcode
//   alu_result, alu_flags     : external ALU outputs
//   op_a, op_b, opcode        : registered operands and operation to the ALU
//   alu_start                 : one-cycle execute pulse
//   result, flags, result_valid : captured ALU output
//   stage                     : display step index 00=A 01=B 10=OP/EXEC 11=RES
//
// Optional feature: define ULA_STEP_DEBOUNCE_EN to insert a DEBOUNCE_CYCLES stability filter on both keys.

module alu_step_controller #(
  parameter int WIDTH           = 8,
  parameter int ALU_LATENCY     = 2,
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic             clk_btn,
  input  logic             rst_btn,
  input  logic             key_advance,
  input  logic             key_back,
  input  logic [WIDTH-1:0] sw_data,
  input  logic [WIDTH-1:0] alu_result,
  input  logic [3:0]       alu_flags,
  output logic [WIDTH-1:0] op_a,
  output logic [WIDTH-1:0] op_b,
  output logic [2:0]       opcode,
  output logic             alu_start,
  output logic [WIDTH-1:0] result,
  output logic [3:0]       flags,
  output logic             result_valid,
  output logic [1:0]       stage
);

  if (ALU_LATENCY < 1 || ALU_LATENCY > 15 || DEBOUNCE_CYCLES < 1) begin : g_bad_param
    $error("alu_step_controller: illegal parameter value");
  end

  typedef enum logic [2:0] {
    S_A    = 3'd0,
    S_B    = 3'd1,
    S_OP   = 3'd2,
    S_EXEC = 3'd3,
    S_RES  = 3'd4
  } state_t;

  localparam logic [3:0] LAT_LAST = 4'(ALU_LATENCY - 1);

  // Key conditioning; bit 0 = advance, bit 1 = back. Everything resets to the
  // idle (released) level so leaving reset never looks like a press.
  logic [1:0] key_raw;
  logic [1:0] sync1;
  logic [1:0] sync2;
  logic [1:0] key_lvl;
  logic [1:0] key_lvl_q;
  logic [1:0] press;
  logic       adv_p;
  logic       back_p;

  assign key_raw = {key_back, key_advance};

  always_ff @(posedge clk_btn) begin
    if (rst_btn) begin
      sync1 <= 2'b11;
      sync2 <= 2'b11;
    end else begin
      sync1 <= key_raw;
      sync2 <= sync1;
    end
  end

`ifdef ULA_STEP_DEBOUNCE_EN
  localparam int DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

  logic [DB_W-1:0] db_cnt [2];
  logic [1:0]      filt;

  // The filtered level follows the synchronized level only after it has
  // disagreed for DEBOUNCE_CYCLES consecutive cycles; any agreement restarts.
  always_ff @(posedge clk_btn) begin
    if (rst_btn) begin
      filt      <= 2'b11;
      db_cnt[0] <= '0;
      db_cnt[1] <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (sync2[i] == filt[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_LAST) begin
          filt[i]   <= sync2[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + DB_W'(1);
        end
      end
    end
  end

  assign key_lvl = filt;
`else
  assign key_lvl = sync2;
`endif

  always_ff @(posedge clk_btn) begin
    if (rst_btn) begin
      key_lvl_q <= 2'b11;
    end else begin
      key_lvl_q <= key_lvl;
    end
  end

  // Falling edge = new press. Coincident presses cancel each other.
  assign press  = key_lvl_q & ~key_lvl;
  assign adv_p  = press[0] & ~press[1];
  assign back_p = press[1] & ~press[0];

  // Step FSM
  state_t     state;
  state_t     state_nxt;
  logic [1:0] stage_nxt;
  logic [3:0] lat_cnt;
  logic       ld_a;
  logic       ld_b;
  logic       ld_op;
  logic       cap;
  logic       clr_rv;

  always_ff @(posedge clk_btn) begin
    if (rst_btn) begin
      state <= S_A;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    ld_a      = 1'b0;
    ld_b      = 1'b0;
    ld_op     = 1'b0;
    cap       = 1'b0;
    clr_rv    = 1'b0;
    unique case (state)
      S_A: begin
        if (adv_p) begin
          ld_a      = 1'b1;
          state_nxt = S_B;
        end
      end
      S_B: begin
        if (adv_p) begin
          ld_b      = 1'b1;
          state_nxt = S_OP;
        end else if (back_p) begin
          state_nxt = S_A;
        end
      end
      S_OP: begin
        if (adv_p) begin
          ld_op     = 1'b1;
          state_nxt = S_EXEC;
        end else if (back_p) begin
          state_nxt = S_B;
        end
      end
      S_EXEC: begin
        // Keys are ignored here; lat_cnt stops at LAT_LAST so exit happens once.
        if (lat_cnt == LAT_LAST) begin
          cap       = 1'b1;
          state_nxt = S_RES;
        end
      end
      S_RES: begin
        if (adv_p) begin
          clr_rv    = 1'b1;
          state_nxt = S_A;
        end else if (back_p) begin
          clr_rv    = 1'b1;
          state_nxt = S_OP;
        end
      end
      default: state_nxt = S_A;
    endcase
  end

  always_comb begin
    stage_nxt = 2'b00;
    unique case (state_nxt)
      S_A:            stage_nxt = 2'b00;
      S_B:            stage_nxt = 2'b01;
      S_OP, S_EXEC:   stage_nxt = 2'b10;
      S_RES:          stage_nxt = 2'b11;
      default:        stage_nxt = 2'b00;
    endcase
  end

  // Registered outputs and datapath
  always_ff @(posedge clk_btn) begin
    if (rst_btn) begin
      stage        <= 2'b00;
      lat_cnt      <= '0;
      alu_start    <= 1'b0;
      op_a         <= '0;
      op_b         <= '0;
      opcode       <= '0;
      result       <= '0;
      flags        <= '0;
      result_valid <= 1'b0;
    end else begin
      stage     <= stage_nxt;
      // alu_start is high during the first S_EXEC cycle, which is cycle 0 of the count.
      alu_start <= ld_op;
      if (ld_op) begin
        lat_cnt <= '0;
      end else if (state == S_EXEC && !cap) begin
        lat_cnt <= lat_cnt + 4'd1;
      end
      if (ld_a) begin
        op_a <= sw_data;
      end
      if (ld_b) begin
        op_b <= sw_data;
      end
      if (ld_op) begin
        opcode <= sw_data[2:0];
      end
      if (cap) begin
        result       <= alu_result;
        flags        <= alu_flags;
        result_valid <= 1'b1;
      end else if (clr_rv) begin
        result_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_alu_step_controller.sv
// Purpose : randomized + directed bench for alu_step_controller with a step-level reference model and scoreboard.
// Latency : model predicts each press acting KLAT edges after the key goes low, capture ALU_LATENCY later.
// Backpressure: none; the monitor pops expectations whenever alu_start pulses or result_valid rises.

module tb_alu_step_controller;

  localparam int W   = 8;
  localparam int L   = 3;
  localparam int DBC = 8;
`ifdef ULA_STEP_DEBOUNCE_EN
  localparam int DB  = DBC;
`else
  localparam int DB  = 0;
`endif
  localparam int KLAT = 3 + DB;

  logic         clk_btn     = 1'b0;
  logic         rst_btn     = 1'b1;
  logic         key_advance = 1'b1;
  logic         key_back    = 1'b1;
  logic [W-1:0] sw_data     = '0;
  logic [W-1:0] alu_result  = '0;
  logic [3:0]   alu_flags   = '0;
  logic [W-1:0] op_a;
  logic [W-1:0] op_b;
  logic [2:0]   opcode;
  logic         alu_start;
  logic [W-1:0] result;
  logic [3:0]   flags;
  logic         result_valid;
  logic [1:0]   stage;

  alu_step_controller #(
    .WIDTH(W), .ALU_LATENCY(L), .DEBOUNCE_CYCLES(DBC)
  ) dut (
    .clk_btn(clk_btn), .rst_btn(rst_btn),
    .key_advance(key_advance), .key_back(key_back),
    .sw_data(sw_data), .alu_result(alu_result), .alu_flags(alu_flags),
    .op_a(op_a), .op_b(op_b), .opcode(opcode), .alu_start(alu_start),
    .result(result), .flags(flags), .result_valid(result_valid), .stage(stage)
  );

  always #5 clk_btn = ~clk_btn;

  int cyc = 0;
  always @(posedge clk_btn) cyc <= cyc + 1;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ALU stand-in: a new random value every cycle, so the captured value pins down the capture edge.
  logic [W-1:0] res_tbl [256];
  logic [3:0]   flg_tbl [256];

  initial begin
    for (int i = 0; i < 256; i++) begin
      res_tbl[i] = W'($urandom);
      flg_tbl[i] = 4'($urandom);
    end
    forever begin
      @(negedge clk_btn);
      alu_result = res_tbl[cyc % 256];
      alu_flags  = flg_tbl[cyc % 256];
    end
  end

  // Reference model: step = 0 A, 1 B, 2 OP, 3 EXEC, 4 RES
  typedef struct {
    int           cap;
    logic [W-1:0] res;
    logic [3:0]   flg;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [2:0]   op;
  } exp_t;

  exp_t sb_q[$];
  int   start_q[$];

  int           m_step = 0;
  int           m_end  = 0;
  logic [W-1:0] m_a = '0, m_b = '0, m_res = '0, m_pres = '0;
  logic [2:0]   m_op = '0;
  logic [3:0]   m_flg = '0, m_pflg = '0;
  logic         m_rv = 1'b0;

  function automatic logic [1:0] stage_of(input int s);
    case (s)
      0: return 2'd0;
      1: return 2'd1;
      2, 3: return 2'd2;
      default: return 2'd3;
    endcase
  endfunction

  task automatic model_reset();
    m_step = 0; m_a = '0; m_b = '0; m_op = '0; m_res = '0; m_flg = '0; m_rv = 1'b0;
    sb_q.delete();
    start_q.delete();
  endtask

  // Bring the model up to the state held after edge x.
  task automatic model_sync(input int x);
    if (m_step == 3 && x >= m_end) begin
      m_step = 4; m_res = m_pres; m_flg = m_pflg; m_rv = 1'b1;
    end
  endtask

  // Press acting at edge t (FSM sees the state after edge t-1).
  task automatic model_press(input bit adv, input bit back, input logic [W-1:0] sw, input int t);
    exp_t e;
    model_sync(t - 1);
    if (adv && back) return;
    if (m_step == 3) return;
    if (adv) begin
      case (m_step)
        0: begin m_a = sw; m_step = 1; end
        1: begin m_b = sw; m_step = 2; end
        2: begin
          m_op   = sw[2:0];
          m_step = 3;
          m_end  = t + L;
          m_pres = res_tbl[(t + L - 1) % 256];
          m_pflg = flg_tbl[(t + L - 1) % 256];
          start_q.push_back(t);
          e.cap = t + L; e.res = m_pres; e.flg = m_pflg; e.a = m_a; e.b = m_b; e.op = m_op;
          sb_q.push_back(e);
        end
        default: begin m_rv = 1'b0; m_step = 0; end
      endcase
    end else if (back) begin
      case (m_step)
        1: m_step = 0;
        2: m_step = 1;
        4: begin m_rv = 1'b0; m_step = 2; end
        default: ;
      endcase
    end
  endtask

  task automatic press(input bit adv, input bit back, input logic [W-1:0] sw, input int hold, input int gap);
    @(negedge clk_btn);
    sw_data = sw;
    if (adv) key_advance = 1'b0;
    if (back) key_back = 1'b0;
    model_press(adv, back, sw, cyc + KLAT);
    repeat (hold + DB) @(negedge clk_btn);
    key_advance = 1'b1;
    key_back    = 1'b1;
    repeat (gap + DB) @(negedge clk_btn);
  endtask

  task automatic check_state(input string tag);
    model_sync(cyc);
    chk({tag, ".stage"}, stage, stage_of(m_step));
    chk({tag, ".op_a"}, op_a, m_a);
    chk({tag, ".op_b"}, op_b, m_b);
    chk({tag, ".opcode"}, opcode, m_op);
    chk({tag, ".result_valid"}, result_valid, m_rv);
    chk({tag, ".result"}, result, m_res);
    chk({tag, ".flags"}, flags, m_flg);
  endtask

  // Monitor: pops expectations on alu_start pulses and result_valid rising edges.
  logic rv_q = 1'b0;
  initial begin
    exp_t e;
    int   s;
    forever begin
      @(negedge clk_btn);
      if (alu_start === 1'b1) begin
        chk("alu_start_in_exec", stage, 2'd2);
        if (start_q.size() == 0) begin
          chk("alu_start_unexpected", alu_start, 1'b0);
        end else begin
          s = start_q.pop_front();
          chk("alu_start_cycle", cyc, s);
        end
      end
      if (result_valid === 1'b1 && rv_q === 1'b0) begin
        if (sb_q.size() == 0) begin
          chk("result_valid_unexpected", result_valid, 1'b0);
        end else begin
          e = sb_q.pop_front();
          chk("capture_cycle", cyc, e.cap);
          chk("sb_result", result, e.res);
          chk("sb_flags", flags, e.flg);
          chk("sb_op_a", op_a, e.a);
          chk("sb_op_b", op_b, e.b);
          chk("sb_opcode", opcode, e.op);
        end
      end
      rv_q = result_valid;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int           p;
    int           e;
    int           hold;
    int           gap;
    int           prev_gap;
    int           r;
    logic [W-1:0] sw;
    logic [W-1:0] cur_sw;

    // Reset values
    repeat (3) @(negedge clk_btn);
    chk("rst.stage", stage, 2'd0);
    chk("rst.op_a", op_a, 0);
    chk("rst.op_b", op_b, 0);
    chk("rst.opcode", opcode, 0);
    chk("rst.result", result, 0);
    chk("rst.flags", flags, 0);
    chk("rst.result_valid", result_valid, 0);
    chk("rst.alu_start", alu_start, 0);
    rst_btn = 1'b0;
    model_reset();
    repeat (4) @(negedge clk_btn);
    check_state("post_reset_idle");

    // Full entry sequence
    press(1, 0, 8'h12, 1, 3);
    check_state("enter_a");
    press(1, 0, 8'h34, 1, 3);
    check_state("enter_b");
    press(1, 0, 8'h03, 1, 3);
    repeat (L + 2) @(negedge clk_btn);
    check_state("exec_done");
    chk("exec_done.opcode_const", opcode, 3'd3);

    // Leave RES, then a 100-cycle hold gives one step
    press(1, 0, 8'h55, 1, 3);
    check_state("res_to_a");
    press(1, 0, 8'hA7, 100, 3);
    check_state("long_hold");

    // Back-stepping
    press(1, 0, 8'h6C, 1, 3);
    check_state("to_op");
    press(0, 1, 8'h00, 1, 3);
    check_state("back_op_b");
    press(0, 1, 8'h00, 1, 3);
    check_state("back_b_a");
    press(0, 1, 8'h00, 1, 3);
    check_state("back_in_a");

    // Simultaneous keys in S_B
    press(1, 0, 8'h21, 1, 3);
    press(1, 1, 8'h21, 1, 3);
    check_state("both_in_b");

    // Advance during S_EXEC is discarded
    press(1, 0, 8'h9E, 1, 3);
    press(1, 0, 8'h05, 1, 0);
    press(1, 0, 8'h05, 1, 3);
    repeat (L + 2) @(negedge clk_btn);
    check_state("exec_press_dropped");
    press(1, 0, 8'h05, 1, 3);
    check_state("leave_res");

    // Reset during S_EXEC
    press(1, 0, 8'h44, 1, 3);
    press(1, 0, 8'h77, 1, 3);
    @(negedge clk_btn);
    sw_data = 8'h06;
    key_advance = 1'b0;
    p = cyc;
    e = p + KLAT;
    model_press(1, 0, 8'h06, e);
    while (cyc < p + 1 + DB) @(negedge clk_btn);
    key_advance = 1'b1;
    while (cyc < e + 1) @(negedge clk_btn);
    chk("pre_abort.stage", stage, 2'd2);
    rst_btn = 1'b1;
    model_reset();
    @(negedge clk_btn);
    rst_btn = 1'b0;
    chk("abort.stage", stage, 2'd0);
    chk("abort.op_a", op_a, 0);
    chk("abort.op_b", op_b, 0);
    chk("abort.opcode", opcode, 0);
    chk("abort.result_valid", result_valid, 0);
    chk("abort.result", result, 0);
    chk("abort.alu_start", alu_start, 0);
    repeat (L + 6) @(negedge clk_btn);
    check_state("after_abort");

`ifdef ULA_STEP_DEBOUNCE_EN
    // Short glitch is filtered out
    @(negedge clk_btn);
    key_advance = 1'b0;
    repeat (5) @(negedge clk_btn);
    key_advance = 1'b1;
    repeat (30) @(negedge clk_btn);
    check_state("glitch");
`endif

    // Randomized presses; gap 0 lets presses land inside S_EXEC
    cur_sw   = '0;
    prev_gap = 3;
    for (int i = 0; i < 80; i++) begin
      r    = $urandom_range(0, 9);
      hold = $urandom_range(1, 4);
      gap  = $urandom_range(0, 4);
      if (prev_gap >= 2) cur_sw = W'($urandom);
      sw = cur_sw;
      if (r < 6)      press(1, 0, sw, hold, gap);
      else if (r < 9) press(0, 1, sw, hold, gap);
      else            press(1, 1, sw, hold, gap);
      if (gap >= 2) check_state("rand");
      prev_gap = gap;
    end

    repeat (L + 12 + 2 * DB) @(negedge clk_btn);
    check_state("final");
    chk("sb_q_drained", sb_q.size(), 0);
    chk("start_q_drained", start_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
